// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC register, zero-latency imem access, BHT/BTB next-PC prediction.
// Build option: define FETCH_BPRED_EN to include the BHT/BTB predictor; otherwise fetch is always sequential.
module fetch_unit #(
  parameter int        PC_W     = 13,
  parameter int        IDX_W    = 6,
  parameter logic [12:0] START_PC = 13'd0
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic            stall,
  input  logic            fail,
  input  logic [PC_W-1:0] nextpc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pcF,
  output logic [31:0]     instF,
  output logic [1:0]      stateF,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [1:0]      upd_state,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] pred_s;

  // Saturating 2-bit counter step, computed from the state carried with the branch
  function automatic logic [1:0] ctr_step(input logic [1:0] st, input logic taken);
    logic [1:0] r;
    if (taken) begin
      r = (st == 2'b11) ? 2'b11 : st + 2'b01;
    end else begin
      r = (st == 2'b00) ? 2'b00 : st - 2'b01;
    end
    return r;
  endfunction

  assign pc_inc_s  = pc_q + PC_W'(1);
  assign imem_addr = pc_q;
  assign pcF       = pc_q;
  assign instF     = imem_rdata;

`ifdef FETCH_BPRED_EN
  localparam int N_ENT = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  logic [1:0]       bht_q     [N_ENT];
  logic             btb_v_q   [N_ENT];
  logic [TAG_W-1:0] btb_tag_q [N_ENT];
  logic [PC_W-1:0]  btb_tgt_q [N_ENT];
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic             hit_s;

  assign idx_s     = pc_q[IDX_W-1:0];
  assign upd_idx_s = upd_pc[IDX_W-1:0];
  assign stateF    = bht_q[idx_s];
  assign hit_s     = btb_v_q[idx_s] && (btb_tag_q[idx_s] == pc_q[PC_W-1:IDX_W]);
  assign pred_s    = (bht_q[idx_s][1] && hit_s) ? btb_tgt_q[idx_s] : pc_inc_s;

  // Predictor tables; tag/target need no reset because valid gates every use
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      for (int i = 0; i < N_ENT; i++) begin
        bht_q[i]   <= 2'b01;
        btb_v_q[i] <= 1'b0;
      end
    end else if (upd_en) begin
      bht_q[upd_idx_s] <= ctr_step(upd_state, upd_taken);
      if (upd_taken) begin
        btb_v_q[upd_idx_s]   <= 1'b1;
        btb_tag_q[upd_idx_s] <= upd_pc[PC_W-1:IDX_W];
        btb_tgt_q[upd_idx_s] <= upd_target;
      end
    end
  end
`else
  logic             unused_upd_s;
  logic [IDX_W-1:0] unused_idx_s;

  assign stateF       = 2'b00;
  assign pred_s       = pc_inc_s;
  assign unused_upd_s = ^{upd_en, upd_pc, upd_state, upd_taken, upd_target, ctr_step(2'b00, 1'b0)};
  assign unused_idx_s = pc_q[IDX_W-1:0];
`endif

  // Next-PC select: a redirect always wins over stall so it is never lost
  always_comb begin
    pc_d = pred_s;
    if (fail) begin
      pc_d = nextpc;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_s;
    end
  end

  // Program counter register
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      pc_q <= START_PC[PC_W-1:0];
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a table model.
module tb_fetch_unit;

`ifdef FETCH_BPRED_EN
  localparam bit BPRED = 1'b1;
`else
  localparam bit BPRED = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        NRST, stall, fail, upd_en, upd_taken;
  logic [12:0] nextpc, imem_addr, pcF, upd_pc, upd_target;
  logic [31:0] imem_rdata, instF;
  logic [1:0]  stateF, upd_state;

  int vectors = 0;
  int errors  = 0;

  int m_pc;
  int m_bht [64];
  bit m_v   [64];
  int m_tag [64];
  int m_tgt [64];

  fetch_unit dut (
    .CLK(CLK), .NRST(NRST), .stall(stall), .fail(fail), .nextpc(nextpc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pcF(pcF), .instF(instF),
    .stateF(stateF), .upd_en(upd_en), .upd_pc(upd_pc), .upd_state(upd_state),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 CLK = ~CLK;

  assign imem_rdata = {imem_addr, imem_addr, 6'h2A};

  function automatic logic [1:0] m_state();
    return BPRED ? 2'(m_bht[m_pc % 64]) : 2'b00;
  endfunction

  function automatic logic [31:0] m_inst();
    logic [12:0] p;
    p = 13'(m_pc);
    return {p, p, 6'h2A};
  endfunction

  task automatic drv(input logic s, input logic f, input int np,
                     input logic ue, input int up, input int us, input logic ut, input int tg);
    stall = s; fail = f; nextpc = 13'(np);
    upd_en = ue; upd_pc = 13'(up); upd_state = 2'(us); upd_taken = ut; upd_target = 13'(tg);
  endtask

  // Advance one clock; the model applies the same edge from the architectural rules
  task automatic tick();
    int i, ui, nxt;
    bit tk;
    @(posedge CLK);
    if (!NRST) begin
      m_pc = 0;
      for (int k = 0; k < 64; k++) begin
        m_bht[k] = 1;
        m_v[k]   = 1'b0;
      end
    end else begin
      i   = m_pc % 64;
      tk  = BPRED && (m_bht[i] >= 2) && m_v[i] && (m_tag[i] == m_pc / 64);
      nxt = tk ? m_tgt[i] : (m_pc + 1) % 8192;
      if (fail) m_pc = int'(nextpc);
      else if (!stall) m_pc = nxt;
      if (BPRED && upd_en) begin
        ui = int'(upd_pc) % 64;
        if (upd_taken) m_bht[ui] = (upd_state == 2'b11) ? 3 : int'(upd_state) + 1;
        else           m_bht[ui] = (upd_state == 2'b00) ? 0 : int'(upd_state) - 1;
        if (upd_taken) begin
          m_v[ui]   = 1'b1;
          m_tag[ui] = int'(upd_pc) / 64;
          m_tgt[ui] = int'(upd_target);
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    drv(1'b0, 1'b1, 13'h123, 1'b1, 5, 3, 1'b1, 13'h77);
    tick();
    tick();
    vectors++;
    if (pcF !== 13'd0) begin errors++; $display("FAIL reset_pc got=%h want=%h", pcF, 13'd0); end
    vectors++;
    if (stateF !== (BPRED ? 2'b01 : 2'b00)) begin
      errors++; $display("FAIL reset_state got=%b want=%b", stateF, BPRED ? 2'b01 : 2'b00);
    end
    NRST = 1'b1;
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_sequential();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (pcF !== 13'(c) || stateF !== m_state() || instF !== m_inst()) begin
        errors++;
        $display("FAIL seq_fetch c=%0d got pc=%h st=%b inst=%h want pc=%h st=%b inst=%h",
                 c, pcF, stateF, instF, 13'(c), m_state(), m_inst());
      end
      tick();
    end
  endtask

  task automatic test_stall();
    drv(1'b0, 1'b1, 5, 1'b0, 0, 0, 1'b0, 0);
    tick();
    drv(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (pcF !== 13'd5) begin errors++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, pcF, 13'd5); end
      tick();
    end
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    vectors++;
    if (pcF !== 13'd5) begin errors++; $display("FAIL stall_last got=%h want=%h", pcF, 13'd5); end
    tick();
    vectors++;
    if (pcF !== 13'd6) begin errors++; $display("FAIL stall_release got=%h want=%h", pcF, 13'd6); end
  endtask

  task automatic test_fail_over_stall();
    drv(1'b1, 1'b1, 13'h040, 1'b0, 0, 0, 1'b0, 0);
    tick();
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    vectors++;
    if (pcF !== 13'h040) begin errors++; $display("FAIL fail_beats_stall got=%h want=%h", pcF, 13'h040); end
  endtask

  task automatic test_wrap();
    drv(1'b0, 1'b1, 13'h1FFF, 1'b0, 0, 0, 1'b0, 0);
    tick();
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    vectors++;
    if (pcF !== 13'h1FFF) begin errors++; $display("FAIL wrap_top got=%h want=%h", pcF, 13'h1FFF); end
    tick();
    vectors++;
    if (pcF !== 13'h0000) begin errors++; $display("FAIL wrap_zero got=%h want=%h", pcF, 13'h0000); end
  endtask

  task automatic test_predictor();
    // Train pc 8 taken to 0x100 while fetching elsewhere
    drv(1'b0, 1'b1, 13'h020, 1'b1, 8, 1, 1'b1, 13'h100);
    tick();
    drv(1'b0, 1'b1, 8, 1'b0, 0, 0, 1'b0, 0);
    tick();
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    vectors++;
    if (pcF !== 13'd8 || stateF !== 2'b10) begin
      errors++; $display("FAIL train_state got pc=%h st=%b want pc=%h st=%b", pcF, stateF, 13'd8, 2'b10);
    end
    tick();
    vectors++;
    if (pcF !== 13'h100) begin errors++; $display("FAIL train_target got=%h want=%h", pcF, 13'h100); end
    // Alias: same index, different tag must fall through
    drv(1'b0, 1'b1, 13'h048, 1'b0, 0, 0, 1'b0, 0);
    tick();
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    vectors++;
    if (stateF !== 2'b10) begin errors++; $display("FAIL alias_state got=%b want=%b", stateF, 2'b10); end
    tick();
    vectors++;
    if (pcF !== 13'h049) begin errors++; $display("FAIL alias_next got=%h want=%h", pcF, 13'h049); end
    // Saturate high, then low
    drv(1'b0, 1'b1, 8, 1'b1, 8, 3, 1'b1, 13'h100);
    tick();
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    vectors++;
    if (stateF !== 2'b11) begin errors++; $display("FAIL sat_high got=%b want=%b", stateF, 2'b11); end
    drv(1'b1, 1'b0, 0, 1'b1, 8, 0, 1'b0, 13'h155);
    tick();
    drv(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    vectors++;
    if (pcF !== 13'd8 || stateF !== 2'b00) begin
      errors++; $display("FAIL sat_low got pc=%h st=%b want pc=%h st=%b", pcF, stateF, 13'd8, 2'b00);
    end
    tick();
    vectors++;
    if (pcF !== 13'd9) begin errors++; $display("FAIL not_taken_next got=%h want=%h", pcF, 13'd9); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      NRST = ($urandom_range(0, 99) != 0);
      drv($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 20),
          $urandom_range(0, 2) == 0, $urandom_range(0, 20), $urandom_range(0, 3),
          $urandom_range(0, 1) == 1, $urandom_range(0, 20));
      tick();
      vectors++;
      if (pcF !== 13'(m_pc) || stateF !== m_state() || instF !== m_inst()) begin
        errors++;
        $display("FAIL random c=%0d got pc=%h st=%b inst=%h want pc=%h st=%b inst=%h",
                 c, pcF, stateF, instF, 13'(m_pc), m_state(), m_inst());
      end
    end
  endtask

  initial begin
    m_pc = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_fail_over_stall();
    test_wrap();
    if (BPRED) test_predictor();
    NRST = 1'b1;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I pipeline. Holds the program counter, drives the asynchronous instruction-memory address, and presents pcF/instF/stateF to the fetch/decode register. Predicts the next PC with a 2-bit-counter branch history table (BHT) and a direct-mapped branch target buffer (BTB). Takes stall and mispredict redirects from the hazard/execute logic, and accepts predictor updates from execute.

## Interface
Parameters:
- PC_W, 13, word-address PC width
- IDX_W, 6, BHT/BTB index width (64 entries, index = pc[IDX_W-1:0])
- START_PC, 13'd0, PC after reset

Ports:
- CLK  in  1  clock, all state updates on rising edge
- NRST  in  1  reset, synchronous, active-low
- stall  in  1  hold PC (decode stage frozen)
- fail  in  1  mispredict redirect (OR of decode/execute mispredict)
- nextpc  in  PC_W  correct PC on redirect
- imem_addr  out  PC_W  instruction-memory word address, combinational read
- imem_rdata  in  32  instruction word at imem_addr, same cycle
- pcF  out  PC_W  PC of fetched instruction
- instF  out  32  fetched instruction (= imem_rdata)
- stateF  out  2  BHT counter value used for this prediction
- upd_en  in  1  predictor update strobe from execute
- upd_pc  in  PC_W  PC of resolved branch
- upd_state  in  2  stateF carried down the pipe with that branch
- upd_taken  in  1  resolved direction
- upd_target  in  PC_W  resolved taken target

## Operation
- State: pc register; bht[2^IDX_W] of 2-bit counters; btb[2^IDX_W] of {valid, tag[PC_W-IDX_W-1:0], target[PC_W-1:0]}, with tag = pc[PC_W-1:IDX_W].
- Reset (NRST=0 at edge): pc=START_PC; every bht entry = 2'b01 (weakly not taken); every btb valid = 0.
- Outputs (combinational from pc): imem_addr=pc, pcF=pc, instF=imem_rdata, stateF=bht[pc idx].
- Predict taken when stateF[1]=1 AND btb[pc idx].valid AND tag match; predicted next = btb target, else pc+1 (mod 2^PC_W, 13'h1FFF wraps to 0).
- Next-pc priority: NRST -> START_PC; fail -> nextpc; stall -> pc; else predicted next.
- fail beats stall: the redirect is never lost.
- Update on upd_en: bht[upd_pc idx] <= upd_state+1 if upd_taken (saturate at 2'b11), else upd_state-1 (saturate at 2'b00). The counter is computed from upd_state, not re-read from the table.
- If upd_taken: btb[upd_pc idx] <= {1, upd_pc tag, upd_target}. A not-taken update leaves the BTB unchanged.
- Updates are independent of stall/fail. An upd_en during reset is ignored.

## Timing
- Zero-latency fetch: the instruction for pc appears on instF in the same cycle as pc.
- Redirect: fail sampled at edge N -> pcF=nextpc in cycle N+1.
- Table write at edge N is visible to a lookup only in cycle N+1. A same-cycle lookup of the same index uses the old entry.
- Stall: pc, and therefore pcF/instF/stateF, held for every stalled cycle. A table update during a stall can change stateF for the held pc on the next cycle.
- Reset mid-operation: all state reinitialised on the next edge regardless of stall/fail/upd_en.

## Configuration
- FETCH_BPRED_EN defined: BHT/BTB present, behaviour as above.
- FETCH_BPRED_EN undefined: no tables. stateF=2'b00 constant. Predicted next is always pc+1. upd_* ports are ignored. fail/stall/reset behaviour is unchanged.

## Test plan
- Reset then run 4 cycles, no stall/fail -> pcF 0,1,2,3; stateF=2'b01 each cycle.
- stall=1 at pc=5 for 3 cycles -> pcF stays 5 for 3 cycles, then 6.
- fail=1 and stall=1 with nextpc=13'h040 -> next cycle pcF=13'h040.
- Predictor training (FETCH_BPRED_EN):
  - upd_en, upd_pc=8, upd_state=2'b01, upd_taken=1, upd_target=13'h100 -> bht[8]=2'b10.
  - Later fetch of pc=8 -> stateF=2'b10, next pcF=13'h100.
- Aliasing: train pc=8 taken, then fetch pc=13'h048 (same idx, different tag) -> next pcF=13'h049.
- Saturation and wrap:
  - upd_state=2'b11 taken -> counter stays 2'b11.
  - upd_state=2'b00 not-taken -> counter stays 2'b00.
  - pc=13'h1FFF not predicted -> next pcF=0.
